// File: rtl/hs_ram_arbiter.sv
// Work-RAM port arbiter between the core CPU and the high-score save/restore engine.
// Pauses the core, settles, waits for vblank (or a timeout), grants the port and hands it back.
module hs_ram_arbiter #(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned VBL_TIMEOUT   = 1048576
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              hs_req,
    input  logic [ADDR_W-1:0] hs_addr,
    input  logic              hs_we,
    input  logic [7:0]        hs_din,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_din,
    input  logic              vblank,
    input  logic              user_pause,
    input  logic              osd_pause,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_din,
    output logic              pause,
    output logic              hs_grant,
    output logic [7:0]        access_cnt
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HOLD     = 3'd1,
        WAIT_VBL = 3'd2,
        GRANT    = 3'd3,
        RELEASE  = 3'd4
    } state_t;

    localparam logic [23:0] SETTLE_LAST = 24'(SETTLE_CYCLES - 1);
    localparam logic [23:0] VBL_LAST    = 24'(VBL_TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [23:0] cnt_reg, cnt_next;
    logic [7:0]  access_cnt_reg, access_cnt_next;
    logic        pause_int_reg, pause_int_next;
    logic        grant_reg, grant_next;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            access_cnt_reg <= '0;
            pause_int_reg  <= 1'b0;
            grant_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            access_cnt_reg <= access_cnt_next;
            pause_int_reg  <= pause_int_next;
            grant_reg      <= grant_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        access_cnt_next = access_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (hs_req) state_next = HOLD;
            end
            HOLD: begin
                if (!hs_req)                   state_next = IDLE;
                else if (cnt_reg == SETTLE_LAST) state_next = WAIT_VBL;
            end
            WAIT_VBL: begin
                if (!hs_req)                 state_next = RELEASE;
                else if (vblank)             state_next = GRANT;
                else if (cnt_reg == VBL_LAST) state_next = GRANT;
            end
            GRANT: begin
                if (!hs_req) begin
                    state_next      = RELEASE;
                    access_cnt_next = access_cnt_reg + 8'd1;
                end
            end
            RELEASE: begin
                // A re-asserted request is deliberately ignored until IDLE.
                if (cnt_reg == SETTLE_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Counter restarts at zero on every state change.
        if (state_next != state_reg)
            cnt_next = '0;
        else if (state_reg == HOLD || state_reg == WAIT_VBL || state_reg == RELEASE)
            cnt_next = cnt_reg + 24'd1;
        else
            cnt_next = '0;

        pause_int_next = (state_next != IDLE);
        grant_next     = (state_next == GRANT);
    end

    always_comb begin
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = 1'b0;
        if (grant_reg) begin
            ram_addr = hs_addr;
            ram_din  = hs_din;
            ram_we   = hs_we;
        end else if (state_reg == IDLE) begin
            ram_we   = cpu_we;
        end
    end

    assign pause      = user_pause | osd_pause | pause_int_reg;
    assign hs_grant   = grant_reg;
    assign access_cnt = access_cnt_reg;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Directed bench for hs_ram_arbiter: settle/vblank/timeout grant timing, release, abort, reset and pause OR.
module tb_hs_ram_arbiter;

    localparam int ADDR_W = 16;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic              hs_req;
    logic [ADDR_W-1:0] hs_addr;
    logic              hs_we;
    logic [7:0]        hs_din;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_we;
    logic [7:0]        cpu_din;
    logic              vblank;
    logic              user_pause;
    logic              osd_pause;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_din;
    logic              pause;
    logic              hs_grant;
    logic [7:0]        access_cnt;

    int checks = 0;
    int errors = 0;

    hs_ram_arbiter #(
        .ADDR_W(ADDR_W),
        .SETTLE_CYCLES(16),
        .VBL_TIMEOUT(100)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .hs_req(hs_req), .hs_addr(hs_addr), .hs_we(hs_we), .hs_din(hs_din),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_din(cpu_din),
        .vblank(vblank), .user_pause(user_pause), .osd_pause(osd_pause),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
        .pause(pause), .hs_grant(hs_grant), .access_cnt(access_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; hs_req = 1'b0; hs_addr = '0; hs_we = 1'b0; hs_din = '0;
        cpu_addr = 16'h1234; cpu_we = 1'b1; cpu_din = 8'hA5;
        vblank = 1'b0; user_pause = 1'b0; osd_pause = 1'b0;
        #22;
        reset_n = 1'b1;
        tick();
        checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL reset_ram_we got %b want 1", ram_we); end
        checks++; if (ram_addr !== 16'h1234) begin errors++; $display("FAIL reset_ram_addr got %h want 1234", ram_addr); end
        checks++; if (ram_din !== 8'hA5) begin errors++; $display("FAIL reset_ram_din got %h want a5", ram_din); end
        checks++; if (pause !== 1'b0) begin errors++; $display("FAIL reset_pause got %b want 0", pause); end
        checks++; if (hs_grant !== 1'b0) begin errors++; $display("FAIL reset_grant got %b want 0", hs_grant); end
        checks++; if (access_cnt !== 8'd0) begin errors++; $display("FAIL reset_access_cnt got %0d want 0", access_cnt); end
        $display("test_reset done");
    endtask

    task automatic test_grant_vblank();
        int n;
        vblank = 1'b1;
        hs_req = 1'b1;
        #1;
        checks++; if (pause !== 1'b0) begin errors++; $display("FAIL req_pause_latency got %b want 0", pause); end
        tick();
        checks++; if (pause !== 1'b1) begin errors++; $display("FAIL req_pause_rise got %b want 1", pause); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL hold_ram_we got %b want 0", ram_we); end
        n = 0;
        while (hs_grant !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++; if (n != 17) begin errors++; $display("FAIL grant_after_pause got %0d cycles want 17", n); end
        hs_addr = 16'hC000; hs_we = 1'b1; hs_din = 8'h3C; cpu_we = 1'b1;
        #1;
        checks++; if (ram_addr !== 16'hC000) begin errors++; $display("FAIL grant_ram_addr got %h want c000", ram_addr); end
        checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL grant_ram_we got %b want 1", ram_we); end
        checks++; if (ram_din !== 8'h3C) begin errors++; $display("FAIL grant_ram_din got %h want 3c", ram_din); end
        hs_we = 1'b0;
        #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL grant_cpu_we_ignored got %b want 0", ram_we); end
        vblank = 1'b0;
        tick(); tick();
        checks++; if (hs_grant !== 1'b1) begin errors++; $display("FAIL grant_held_after_vbl got %b want 1", hs_grant); end
        $display("test_grant_vblank done: grant after %0d cycles", n);
    endtask

    task automatic test_release(input logic [7:0] exp_cnt);
        int n;
        hs_req = 1'b0;
        tick();
        checks++; if (hs_grant !== 1'b0) begin errors++; $display("FAIL release_grant got %b want 0", hs_grant); end
        checks++; if (access_cnt !== exp_cnt) begin errors++; $display("FAIL release_access_cnt got %0d want %0d", access_cnt, exp_cnt); end
        checks++; if (ram_we !== 1'b0 || ram_addr !== cpu_addr) begin errors++; $display("FAIL release_mux got we=%b addr=%h want we=0 addr=%h", ram_we, ram_addr, cpu_addr); end
        n = 0;
        while (pause !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        checks++; if (n != 16) begin errors++; $display("FAIL release_pause_len got %0d want 16", n); end
        checks++; if (ram_we !== cpu_we) begin errors++; $display("FAIL release_cpu_we got %b want %b", ram_we, cpu_we); end
        $display("test_release done: access_cnt=%0d pause held %0d cycles", access_cnt, n);
    endtask

    task automatic test_timeout();
        int n;
        vblank = 1'b0;
        hs_req = 1'b1;
        n = 0;
        while (hs_grant !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        // 1 edge into HOLD, 16 in HOLD, 100 in WAIT_VBL
        checks++; if (n != 117) begin errors++; $display("FAIL timeout_grant got %0d cycles want 117", n); end
        $display("test_timeout done: grant after %0d cycles", n);
    endtask

    task automatic test_abort();
        logic seen_grant;
        seen_grant = 1'b0;
        hs_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen_grant |= hs_grant;
        end
        checks++; if (pause !== 1'b1) begin errors++; $display("FAIL abort_pause_before got %b want 1", pause); end
        hs_req = 1'b0;
        tick();
        checks++; if (pause !== 1'b0) begin errors++; $display("FAIL abort_pause_after got %b want 0", pause); end
        for (int i = 0; i < 20; i++) begin
            tick();
            seen_grant |= hs_grant;
        end
        checks++; if (seen_grant !== 1'b0) begin errors++; $display("FAIL abort_no_grant got %b want 0", seen_grant); end
        checks++; if (access_cnt !== 8'd2) begin errors++; $display("FAIL abort_access_cnt got %0d want 2", access_cnt); end
        $display("test_abort done");
    endtask

    task automatic test_reset_mid_grant();
        int n;
        vblank = 1'b1;
        hs_req = 1'b1;
        cpu_addr = 16'h5678;
        hs_addr = 16'hC001;
        n = 0;
        while (hs_grant !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++; if (n != 18) begin errors++; $display("FAIL reset_grant_reach got %0d want 18", n); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (hs_grant !== 1'b0) begin errors++; $display("FAIL async_grant got %b want 0", hs_grant); end
        checks++; if (ram_addr !== 16'h5678) begin errors++; $display("FAIL async_mux got %h want 5678", ram_addr); end
        checks++; if (access_cnt !== 8'd0) begin errors++; $display("FAIL async_access_cnt got %0d want 0", access_cnt); end
        checks++; if (pause !== 1'b0) begin errors++; $display("FAIL async_pause got %b want 0", pause); end
        hs_req = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        $display("test_reset_mid_grant done");
    endtask

    task automatic test_user_pause();
        user_pause = 1'b1;
        cpu_we = 1'b1;
        tick(); tick();
        checks++; if (pause !== 1'b1) begin errors++; $display("FAIL user_pause got %b want 1", pause); end
        checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL user_pause_ram_we got %b want 1", ram_we); end
        checks++; if (hs_grant !== 1'b0) begin errors++; $display("FAIL user_pause_grant got %b want 0", hs_grant); end
        user_pause = 1'b0; osd_pause = 1'b1;
        #1;
        checks++; if (pause !== 1'b1) begin errors++; $display("FAIL osd_pause got %b want 1", pause); end
        osd_pause = 1'b0;
        #1;
        checks++; if (pause !== 1'b0) begin errors++; $display("FAIL pause_clear got %b want 0", pause); end
        $display("test_user_pause done");
    endtask

    initial begin
        test_reset();
        test_grant_vblank();
        test_release(8'd1);
        tick();
        test_timeout();
        test_release(8'd2);
        tick();
        test_abort();
        test_reset_mid_grant();
        test_user_pause();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/hs_ram_arbiter.md
Name: hs_ram_arbiter

Overview:
- Shares the game core's work-RAM port between the CPU datapath and the high-score save/restore engine.
- On a high-score access request it pauses the core and waits a settle window. It then waits for vertical blank (with a fallback timeout), grants the RAM port to the high-score engine, and hands the port back cleanly.
- Sits between the hiscore engine, the pause logic and the SEGASYSTEM1 core RAM port. Also produces the combined pause signal.

Parameters:
- ADDR_W, 16, RAM address width.
- SETTLE_CYCLES, 16, cycles pause is held before grant and after release (range 1..255).
- VBL_TIMEOUT, 1048576, max cycles spent waiting for vblank before granting anyway (range 1..2^24-1).

Ports:
- clk_sys  in  1  system clock (40 MHz).
- reset_n  in  1  asynchronous active-low reset.
- hs_req  in  1  high-score engine requests RAM ownership (level).
- hs_addr  in  ADDR_W  high-score RAM address.
- hs_we  in  1  high-score write strobe.
- hs_din  in  8  high-score write data.
- cpu_addr  in  ADDR_W  core RAM address.
- cpu_we  in  1  core RAM write strobe.
- cpu_din  in  8  core write data.
- vblank  in  1  vertical blank from video timing.
- user_pause  in  1  user pause toggle state.
- osd_pause  in  1  OSD-open pause request, already qualified by the menu option.
- ram_addr  out  ADDR_W  muxed RAM address.
- ram_we  out  1  muxed RAM write strobe.
- ram_din  out  8  muxed RAM write data.
- pause  out  1  combined core pause (active high).
- hs_grant  out  1  RAM port owned by the high-score engine.
- access_cnt  out  8  number of completed grants, wraps at 255->0.

Behaviour:
- States: IDLE, HOLD, WAIT_VBL, GRANT, RELEASE. A single counter (24 bit) is shared by HOLD, WAIT_VBL and RELEASE and is cleared on every state entry.
- Reset (async, reset_n=0) forces:
  - state IDLE, counter 0, access_cnt 0, hs_grant 0;
  - registered pause_int 0.
- Combinational outputs: pause = user_pause | osd_pause | pause_int. With no pause inputs, pause is 0 immediately after reset.
- IDLE: pause_int 0.
  - hs_req=1 -> HOLD on the next edge. pause_int becomes 1 on that same edge (1-cycle latency req->pause).
- HOLD: counter increments each cycle.
  - hs_req=0 -> IDLE (abort, no grant, access_cnt unchanged).
  - Otherwise, counter==SETTLE_CYCLES-1 -> WAIT_VBL.
- WAIT_VBL: counter increments each cycle.
  - hs_req=0 -> RELEASE.
  - vblank=1 -> GRANT.
  - Counter==VBL_TIMEOUT-1 -> GRANT (fallback when video is stopped).
  - vblank takes priority over the timeout in the same cycle; the result is identical either way.
- GRANT: hs_grant=1 (registered, asserted the cycle the state is GRANT).
  - Stay while hs_req=1. The grant is not revoked by vblank ending.
  - hs_req=0 -> RELEASE. access_cnt increments on this transition.
- RELEASE: hs_grant 0, pause_int stays 1, counter increments.
  - counter==SETTLE_CYCLES-1 -> IDLE, pause_int 0.
  - hs_req re-asserted during RELEASE is ignored until IDLE is reached; IDLE then goes to HOLD on the next cycle. Minimum 1 IDLE cycle between grants.
- RAM mux (combinational):
  - In GRANT: ram_addr=hs_addr, ram_din=hs_din, ram_we=hs_we.
  - In all other states: ram_addr=cpu_addr, ram_din=cpu_din.
    - ram_we=cpu_we only in IDLE.
    - ram_we=0 in HOLD, WAIT_VBL and RELEASE, so a paused CPU cannot write.
- hs_we outside GRANT is discarded.
- user_pause and osd_pause never affect the arbiter state. They only OR into pause.
- reset_n asserted mid-GRANT: hs_grant drops asynchronously and the mux returns to the CPU. No access_cnt increment.

Test Plan:
- Reset, no requests, cpu_we=1, cpu_addr=0x1234, cpu_din=0xA5 -> ram_we=1, ram_addr=0x1234, ram_din=0xA5; pause=0, hs_grant=0, access_cnt=0.
- hs_req rises, vblank held 1, SETTLE_CYCLES=16 -> pause=1 one cycle later; hs_grant=1 exactly 17 cycles after pause rose. While granted, hs_addr=0xC000, hs_we=1, hs_din=0x3C appear on the RAM port, and cpu_we is ignored.
- hs_req drops in GRANT -> hs_grant=0 next cycle; access_cnt 0->1; pause stays 1 for 16 cycles, then 0; ram_we follows cpu_we again.
- vblank held 0, VBL_TIMEOUT=100 (bench override) -> grant asserted 100 cycles after entering WAIT_VBL.
- hs_req pulses for 5 cycles (aborted in HOLD) -> no grant, access_cnt unchanged, pause returns to 0 the cycle after the abort.
- reset_n pulsed low mid-GRANT; separately, user_pause=1 with hs_req=0 -> all outputs return to reset values, access_cnt=0. With user_pause=1, pause=1, state stays IDLE and ram_we follows cpu_we.
